ahb_ram_slave: RTL
==================

# ahb_ram_slave

AHB-Lite responder that converts single-master AHB transfers into the chip's synchronous single-port RAM interface: word address, active-low byte write enables, and a read/write-not strobe. Each RAM bank pair in the chip sits behind one instance; the Router drives its address/control/data lines and receives `hrdata`/`hreadyout`/`hresp`. Writes complete with zero wait states. Reads take one wait state to cover the RAM's registered output.

## Interface
Parameters:
- `ADDR_W`, default 14: RAM word-address width. `haddr[ADDR_W+1:2]` selects the word; upper bits are ignored because the Router decodes them into `hsel`.

Ports:
- `clk`, in, 1: sole clock; all state changes on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `hsel`, in, 1: slave select from Router decode.
- `haddr`, in, 32: byte address.
- `htrans`, in, 2: only `htrans[1]` (NONSEQ/SEQ) is used.
- `hwrite`, in, 1: 1 = write.
- `hsize`, in, 3: 0 = byte, 1 = half, 2 = word.
- `hburst` (3), `hmastlock` (1), `hprot` (4), in: accepted and ignored.
- `hwdata`, in, 32: write data, valid in the data phase.
- `hready_in`, in, 1: bus HREADY.
- `hreadyout`, out, 1: this slave's ready.
- `hresp`, out, 1: 0 = OKAY, 1 = ERROR.
- `hrdata`, out, 32: read data.
- `ram_addr`, out, ADDR_W: RAM word address.
- `ram_write`, out, 32: RAM write data.
- `ram_read`, in, 32: RAM data; registered inside the RAM, valid the cycle after the address.
- `ram_rwn`, out, 1: 1 = read/idle, 0 = write.
- `ram_wben`, out, 4: active-low byte-lane enables. Lane i is written only when `ram_rwn`=0 and `ram_wben[i]`=0.

## Operation
- **Accept:** a transfer is accepted when `hsel & htrans[1] & hready_in` = 1. On acceptance, register the word address, `hwrite`, the lane mask and the error flag.
- **Idle/busy beats:** `htrans[1]`=0, or `hsel`=0, gives an OKAY response with zero wait states and changes no state.
- **Lane mask (little-endian):**
  - `hsize`=0: lane `haddr[1:0]`.
  - `hsize`=1: lanes {1,0} if `haddr[1]`=0, else {3,2}.
  - `hsize`=2: all four lanes.
  - `ram_wben` is the inverted mask.
- **FSM states:**
  - IDLE: `hreadyout`=1, `hresp`=0.
  - WR_DATA: `ram_rwn`=0, `ram_addr` = registered address, `ram_write` = `hwdata` (combinational), `ram_wben` = ~mask, `hreadyout`=1.
  - RD_ISSUE: `ram_rwn`=1, `ram_addr` = registered address, `hreadyout`=0.
  - RD_DATA: `hrdata` = `ram_read`, `hreadyout`=1.
  - ERR1: `hreadyout`=0, `hresp`=1.
  - ERR2: `hreadyout`=1, `hresp`=1.
- **Transitions:**
  - An accepted write goes to WR_DATA; an accepted read goes to RD_ISSUE; an accepted erroneous transfer goes to ERR1.
  - RD_ISSUE always goes to RD_DATA.
  - ERR1 always goes to ERR2.
  - From IDLE, WR_DATA, RD_DATA or ERR2, the next state is taken from the acceptance decision in that cycle, or IDLE if nothing is accepted.
- **Back-to-back transfers:**
  - Write then read: the read issues in the cycle after the write's data phase, so there is no port conflict.
  - Read then write: the write address phase overlaps RD_DATA.
- **Outputs outside their active state:** `ram_rwn`=1, `ram_wben`=4'hF, `ram_write`=0, `hrdata`=0; `ram_addr` holds its last value.
- **Reset:** forces IDLE at the next edge. While `reset`=1, `ram_rwn` is held at 1, so a write pending in its data phase is dropped. Reset values: `hreadyout`=1, `hresp`=0, `hrdata`=0, `ram_rwn`=1, `ram_wben`=4'hF, `ram_addr`=0, `ram_write`=0.

## Timing
- **Write:** address phase in cycle A; RAM write at the end of A+1; `hreadyout`=1 throughout (zero wait).
- **Read:** address phase in A; `hreadyout`=0 in A+1; `hrdata` valid with `hreadyout`=1 in A+2.
- **Error:** `hresp`=1 in both A+1 and A+2; `hreadyout` is 0 then 1. No RAM access occurs.
- **Read throughput:** back-to-back reads sustain one word every 2 cycles.

## Configuration
- `AHB_RAM_SLAVE_ERR_EN` defined: the error flag is set for `hsize`>2, or for a misaligned half (`haddr[0]`=1) or word (`haddr[1:0]`≠0). Flagged transfers take the ERR1→ERR2 path.
- Not defined: the error flag is tied to 0 and `hresp` is constant 0. Misaligned addresses have their low bits forced to alignment; `hsize`>2 is treated as a word access.

## Test plan
- Word write 0xDEADBEEF to haddr 0x10, then word read from 0x10 → `ram_addr`=4; `ram_wben`=4'h0 during the write; `hrdata`=0xDEADBEEF two cycles after the read address phase, with one `hreadyout`=0 cycle.
- Byte write 0xAB at 0x13 over a word of 0 → `ram_wben`=4'b0111; the readback word is 0xAB000000.
- Back-to-back write(0x20, 0x11223344) then read(0x20) with no idle cycle → the read returns 0x11223344 and no RAM write occurs in RD_ISSUE.
- With `AHB_RAM_SLAVE_ERR_EN` defined, word read at 0x22 → `hresp`=1 for 2 cycles, `hreadyout` 0 then 1, `ram_rwn` stays 1. Without the macro, the same access reads word 8 with `hresp`=0.
- Assert `reset` during WR_DATA of a write to 0x30 → no write occurs (word 12 unchanged); after reset, `hreadyout`=1, `hresp`=0, `ram_wben`=4'hF.
- `htrans`=BUSY with `hsel`=1, or `htrans`=NONSEQ with `hsel`=0 → `hreadyout` stays 1, `ram_rwn` stays 1, and the FSM stays in IDLE.

Source files
------------

// File: rtl/ahb_ram_slave.sv
`default_nettype none
// ============================================================================
// Module : ahb_ram_slave
// Brief  : AHB-Lite responder in front of a synchronous single-port RAM.
//          Zero-wait writes, one-wait reads. Optional macro
//          AHB_RAM_SLAVE_ERR_EN enables ERROR responses for bad size/alignment.
// Rev    : 1.0  initial release
// ============================================================================
module ahb_ram_slave #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hsel,
   input  logic [31:0]       haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [2:0]        hburst,
   input  logic              hmastlock,
   input  logic [3:0]        hprot,
   input  logic [31:0]       hwdata,
   input  logic              hready_in,
   output logic              hreadyout,
   output logic              hresp,
   output logic [31:0]       hrdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_write,
   input  logic [31:0]       ram_read,
   output logic              ram_rwn,
   output logic [3:0]        ram_wben
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WR_DATA  = 3'd1,
      S_RD_ISSUE = 3'd2,
      S_RD_DATA  = 3'd3,
      S_ERR1     = 3'd4,
      S_ERR2     = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [3:0]          r_mask;
   logic [3:0]          w_mask;
   logic                w_err;
   logic                w_accept;
   logic                w_take;

   // Burst/lock/protection and the upper address bits are decoded elsewhere.
   logic w_unused;
   assign w_unused = ^{hburst, hmastlock, hprot, htrans[0], haddr[31:ADDR_W+2]};

   assign w_accept = hsel & htrans[1] & hready_in;

   always_comb begin
      w_mask = 4'hF;
      case (hsize)
         3'd0:    w_mask = 4'b0001 << haddr[1:0];
         3'd1:    w_mask = haddr[1] ? 4'b1100 : 4'b0011;
         default: w_mask = 4'hF;
      endcase
   end

`ifdef AHB_RAM_SLAVE_ERR_EN
   assign w_err = (hsize > 3'd2)
                | ((hsize == 3'd1) & haddr[0])
                | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
`else
   assign w_err = 1'b0;
`endif

   // The wait-state cycles never sample a new address phase.
   assign w_take = w_accept & (r_state != S_RD_ISSUE) & (r_state != S_ERR1);

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_RD_ISSUE: w_next = S_RD_DATA;
         S_ERR1:     w_next = S_ERR2;
         default: begin
            if (w_take) begin
               if (w_err)       w_next = S_ERR1;
               else if (hwrite) w_next = S_WR_DATA;
               else             w_next = S_RD_ISSUE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_mask  <= 4'h0;
      end else begin
         r_state <= w_next;
         // Errored transfers leave the RAM address untouched.
         if (w_take && !w_err) begin
            r_addr <= haddr[ADDR_W+1:2];
            r_mask <= w_mask;
         end
      end
   end

   assign ram_addr = r_addr;

   always_comb begin
      hreadyout = 1'b1;
      hresp     = 1'b0;
      hrdata    = 32'h0;
      ram_rwn   = 1'b1;
      ram_wben  = 4'hF;
      ram_write = 32'h0;
      // Reset suppresses a write still in its data phase.
      if (!reset) begin
         case (r_state)
            S_WR_DATA: begin
               ram_rwn   = 1'b0;
               ram_write = hwdata;
               ram_wben  = ~r_mask;
            end
            S_RD_ISSUE: hreadyout = 1'b0;
            S_RD_DATA:  hrdata    = ram_read;
`ifdef AHB_RAM_SLAVE_ERR_EN
            S_ERR1: begin
               hreadyout = 1'b0;
               hresp     = 1'b1;
            end
            S_ERR2: hresp = 1'b1;
`endif
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
